// File: rtl/rs_dec_payload_extractor.sv
// Strips the trailing parity symbols from each corrected RS codeword, buffers the payload
// in a first-word-registered FIFO and reports per-codeword framing and decode status.
module rs_dec_payload_extractor #(
    parameter int M       = 8,
    parameter int N       = 255,
    parameter int CHECK   = 8,
    parameter int WIDE    = 4,
    parameter int FIFO_AW = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            sink_val,
    input  logic            sink_sop,
    input  logic            sink_eop,
    input  logic [M-1:0]    rsout,
    input  logic            decfail,
    input  logic [WIDE-1:0] num_err_sym,
    output logic            sink_ena,
    output logic [M-1:0]    out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            blk_done,
    output logic            blk_fail,
    output logic [WIDE-1:0] blk_err_cnt,
    output logic            blk_len_err,
    output logic            ovf
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int D  = 2 ** FIFO_AW;
    localparam logic [IW-1:0]    LAST_IDX = IW'(N - 1);
    localparam logic [IW-1:0]    PAY_LEN  = IW'(N - CHECK);
    localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(D);
    localparam logic [FIFO_AW:0] ENA_CNT  = (FIFO_AW + 1)'(D - 2);

    typedef enum logic [0:0] {IDLE = 1'b0, DATA = 1'b1} state_t;

    state_t              state_r, state_s;
    logic [IW-1:0]       idx_r, idx_s;
    logic [IW-1:0]       cur_idx_s;
    logic                in_blk_s, abort_s, end_s;
    logic                pay_s, done_s, len_err_s;

    logic [M-1:0]        mem_r [D];
    logic [FIFO_AW-1:0]  wr_ptr_r, rd_ptr_r, rd_ptr_s;
    logic [FIFO_AW:0]    count_r, count_s, cnt_after_rd_s;
    logic                do_read_s, do_write_s, drop_s;
    logic [M-1:0]        head_s;

    logic                sink_ena_r, out_valid_r, blk_done_r, blk_fail_r, blk_len_err_r, ovf_r;
    logic [M-1:0]        out_data_r;
    logic [WIDE-1:0]     blk_err_cnt_r;

    // A sop beat always restarts at index 0, even when it aborts a running block.
    assign in_blk_s  = sink_val && (state_r == DATA || sink_sop);
    assign abort_s   = sink_val && (state_r == DATA) && sink_sop;
    assign cur_idx_s = (state_r == DATA && !sink_sop) ? idx_r : {IW{1'b0}};
    assign end_s     = sink_eop || (cur_idx_s == LAST_IDX);

    // Framing state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            idx_r   <= {IW{1'b0}};
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
        end
    end

    // Framing next-state: idx holds the index expected for the next beat
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        if (!sink_val) begin
            state_s = state_r;
        end else if (!in_blk_s || end_s) begin
            state_s = IDLE;
            idx_s   = {IW{1'b0}};
        end else begin
            state_s = DATA;
            idx_s   = cur_idx_s + IW'(1);
        end
    end

    // Framing outputs: payload strobe and status events for this beat
    always_comb begin
        pay_s     = 1'b0;
        done_s    = 1'b0;
        len_err_s = 1'b0;
        case (state_r)
            IDLE, DATA: begin
                if (in_blk_s) begin
                    pay_s     = (cur_idx_s < PAY_LEN);
                    done_s    = !abort_s && sink_eop && (cur_idx_s == LAST_IDX);
                    len_err_s = abort_s || (end_s && !done_s);
                end else begin
                    len_err_s = sink_val;
                end
            end
            default: begin
                pay_s     = 1'b0;
                done_s    = 1'b0;
                len_err_s = 1'b0;
            end
        endcase
    end

    assign do_read_s      = out_valid_r && out_ready;
    assign do_write_s     = pay_s && ((count_r != FULL_CNT) || do_read_s);
    assign drop_s         = pay_s && !do_write_s;
    assign cnt_after_rd_s = count_r - (FIFO_AW + 1)'(do_read_s);
    assign count_s        = cnt_after_rd_s + (FIFO_AW + 1)'(do_write_s);
    assign rd_ptr_s       = rd_ptr_r + FIFO_AW'(do_read_s);
    // An incoming symbol becomes the head directly when nothing else is left to present.
    assign head_s         = (do_write_s && cnt_after_rd_s == {(FIFO_AW + 1){1'b0}}) ? rsout : mem_r[rd_ptr_s];

    // FIFO storage (contents are don't-care after reset; pointers define validity)
    always_ff @(posedge clk) begin
        if (do_write_s) begin
            mem_r[wr_ptr_r] <= rsout;
        end
    end

    // FIFO pointers, registered head, backpressure and status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r      <= {FIFO_AW{1'b0}};
            rd_ptr_r      <= {FIFO_AW{1'b0}};
            count_r       <= {(FIFO_AW + 1){1'b0}};
            out_valid_r   <= 1'b0;
            out_data_r    <= {M{1'b0}};
            sink_ena_r    <= 1'b1;
            blk_done_r    <= 1'b0;
            blk_fail_r    <= 1'b0;
            blk_err_cnt_r <= {WIDE{1'b0}};
            blk_len_err_r <= 1'b0;
            ovf_r         <= 1'b0;
        end else begin
            wr_ptr_r      <= wr_ptr_r + FIFO_AW'(do_write_s);
            rd_ptr_r      <= rd_ptr_s;
            count_r       <= count_s;
            out_valid_r   <= (count_s != {(FIFO_AW + 1){1'b0}});
            if (count_s != {(FIFO_AW + 1){1'b0}}) begin
                out_data_r <= head_s;
            end
            sink_ena_r    <= (count_s <= ENA_CNT);
            blk_done_r    <= done_s;
            blk_len_err_r <= len_err_s;
            if (done_s) begin
                blk_fail_r    <= decfail;
                blk_err_cnt_r <= num_err_sym;
            end
            if (drop_s) begin
                ovf_r <= 1'b1;
            end
        end
    end

    assign sink_ena    = sink_ena_r;
    assign out_data    = out_data_r;
    assign out_valid   = out_valid_r;
    assign blk_done    = blk_done_r;
    assign blk_fail    = blk_fail_r;
    assign blk_err_cnt = blk_err_cnt_r;
    assign blk_len_err = blk_len_err_r;
    assign ovf         = ovf_r;
endmodule

// File: tb/tb_rs_dec_payload_extractor.sv
// Scoreboard bench: stimulus pushes expected payload/status into queues, a negedge monitor
// pops and compares on every output transfer and every blk_done pulse.
module tb_rs_dec_payload_extractor;
    localparam int M = 8, N = 255, CHECK = 8, WIDE = 4, FIFO_AW = 4;
    localparam int PAY = N - CHECK;

    logic            clk = 1'b0;
    logic            reset, sink_val, sink_sop, sink_eop, decfail, out_ready;
    logic [M-1:0]    rsout;
    logic [WIDE-1:0] num_err_sym;
    logic            sink_ena, out_valid, blk_done, blk_fail, blk_len_err, ovf;
    logic [M-1:0]    out_data;
    logic [WIDE-1:0] blk_err_cnt;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    int lerr_cnt = 0;
    logic            ena_d = 1'b1;
    logic [M-1:0]    exp_q[$];
    logic [WIDE:0]   stat_q[$];

    always #5 clk = ~clk;

    rs_dec_payload_extractor #(.M(M), .N(N), .CHECK(CHECK), .WIDE(WIDE), .FIFO_AW(FIFO_AW)) dut (
        .clk(clk), .reset(reset), .sink_val(sink_val), .sink_sop(sink_sop), .sink_eop(sink_eop),
        .rsout(rsout), .decfail(decfail), .num_err_sym(num_err_sym), .sink_ena(sink_ena),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .blk_done(blk_done),
        .blk_fail(blk_fail), .blk_err_cnt(blk_err_cnt), .blk_len_err(blk_len_err), .ovf(ovf)
    );

    // Decoder model uses the sink_ena it saw one cycle earlier (1-cycle slack).
    always @(posedge clk) ena_d <= sink_ena;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic flag_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Monitor: pops expected payload on each transfer and expected status on each blk_done.
    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) flag_fail("unexpected_out_data");
                else check("out_data", 32'(out_data), 32'(exp_q.pop_front()));
            end
            if (blk_done && blk_len_err) flag_fail("done_and_len_err_together");
            if (blk_done) begin
                done_cnt++;
                if (stat_q.size() == 0) flag_fail("unexpected_blk_done");
                else check("blk_status", 32'({blk_fail, blk_err_cnt}), 32'(stat_q.pop_front()));
            end
            if (blk_len_err) lerr_cnt++;
        end
    end

    task automatic idle_inputs();
        sink_val = 1'b0; sink_sop = 1'b0; sink_eop = 1'b0;
        rsout = '0; decfail = 1'b0; num_err_sym = '0;
    endtask

    task automatic send(input logic sop, input logic eop, input logic [M-1:0] sym,
                        input logic df, input logic [WIDE-1:0] ne);
        int w = 0;
        while (!ena_d && w < 200) begin
            @(posedge clk); #1; w++;
        end
        if (w >= 200) flag_fail("sink_ena_timeout");
        sink_val = 1'b1; sink_sop = sop; sink_eop = eop; rsout = sym;
        decfail = eop ? df : 1'b0;
        num_err_sym = eop ? ne : '0;
        @(posedge clk); #1;
        idle_inputs();
    endtask

    task automatic send_block(input int nbeats, input int eop_at, input logic [M-1:0] base,
                              input logic df, input logic [WIDE-1:0] ne, input logic good);
        for (int i = 0; i < nbeats; i++) begin
            logic [M-1:0] sym;
            sym = base + M'(i);
            if (i < PAY) exp_q.push_back(sym);
            send(i == 0, i == eop_at, sym, df, ne);
        end
        if (good) stat_q.push_back({df, ne});
    endtask

    task automatic drain();
        int w = 0;
        while ((exp_q.size() != 0 || out_valid) && w < 400) begin
            @(posedge clk); #1; w++;
        end
        repeat (2) begin @(posedge clk); #1; end
        check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int sent;
        reset = 1'b1; out_ready = 1'b0;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_sink_ena", 32'(sink_ena), 32'd1);
        check("rst_flags", 32'({blk_done, blk_fail, blk_len_err, ovf}), 32'd0);
        check("rst_err_cnt", 32'(blk_err_cnt), 32'd0);

        // Clean block: 247 payload symbols, one blk_done, status 0/0
        out_ready = 1'b1;
        send_block(N, N - 1, 8'h00, 1'b0, 4'd0, 1'b1);
        drain();
        check("t1_done_cnt", 32'(done_cnt), 32'd1);
        check("t1_lerr_cnt", 32'(lerr_cnt), 32'd0);
        check("t1_blk_fail", 32'(blk_fail), 32'd0);

        // decfail with 5 corrected symbols
        send_block(N, N - 1, 8'h40, 1'b1, 4'd5, 1'b1);
        drain();
        check("t2_done_cnt", 32'(done_cnt), 32'd2);
        check("t2_blk_fail", 32'(blk_fail), 32'd1);
        check("t2_err_cnt", 32'(blk_err_cnt), 32'd5);

        // Early eop at idx 100: length error, status untouched, then a normal block
        send_block(101, 100, 8'h10, 1'b0, 4'd9, 1'b0);
        drain();
        check("t4_lerr_cnt", 32'(lerr_cnt), 32'd1);
        check("t4_done_cnt", 32'(done_cnt), 32'd2);
        check("t4_status_held", 32'({blk_fail, blk_err_cnt}), 32'({1'b1, 4'd5}));
        send_block(N, N - 1, 8'h80, 1'b0, 4'd3, 1'b1);
        drain();
        check("t4_done_after", 32'(done_cnt), 32'd3);
        check("t4_err_cnt_after", 32'(blk_err_cnt), 32'd3);

        // sop at idx 50 restarts the block; the new block completes
        send_block(50, -1, 8'h20, 1'b0, 4'd0, 1'b0);
        send_block(N, N - 1, 8'h33, 1'b0, 4'd7, 1'b1);
        drain();
        check("t5_lerr_cnt", 32'(lerr_cnt), 32'd2);
        check("t5_done_cnt", 32'(done_cnt), 32'd4);
        check("t5_err_cnt", 32'(blk_err_cnt), 32'd7);

        // Consumer stalled: slack-honouring decoder fills exactly 16 entries, no overflow
        out_ready = 1'b0;
        sent = 0;
        for (int c = 0; c < 40; c++) begin
            if (ena_d) begin
                sink_val = 1'b1; sink_sop = (sent == 0); rsout = 8'hC0 + M'(sent);
                exp_q.push_back(8'hC0 + M'(sent));
                sent++;
            end else begin
                idle_inputs();
            end
            @(posedge clk); #1;
        end
        idle_inputs();
        check("t3_beats_accepted", 32'(sent), 32'd16);
        check("t3_ovf", 32'(ovf), 32'd0);
        check("t3_sink_ena", 32'(sink_ena), 32'd0);
        check("t3_out_valid", 32'(out_valid), 32'd1);
        check("t3_head_held", 32'(out_data), 32'hC0);
        out_ready = 1'b1;
        drain();
        check("t3_ovf_after", 32'(ovf), 32'd0);

        // Reset mid-block with 8 symbols buffered (sop aborts the stalled block)
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(i == 0, 1'b0, 8'hE0 + M'(i), 1'b0, 4'd0);
        @(posedge clk); #1;
        check("t6_lerr_cnt", 32'(lerr_cnt), 32'd3);
        check("t6_pre_valid", 32'(out_valid), 32'd1);
        check("t6_pre_sink_ena", 32'(sink_ena), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("t6_out_valid", 32'(out_valid), 32'd0);
        check("t6_out_data", 32'(out_data), 32'd0);
        check("t6_sink_ena", 32'(sink_ena), 32'd1);
        check("t6_flags", 32'({blk_done, blk_fail, blk_len_err, ovf}), 32'd0);
        check("t6_err_cnt", 32'(blk_err_cnt), 32'd0);
        out_ready = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        check("t6_fifo_lost", 32'(out_valid), 32'd0);

        // Recovery block after reset
        send_block(N, N - 1, 8'h01, 1'b0, 4'd2, 1'b1);
        drain();
        check("t6_done_cnt", 32'(done_cnt), 32'd5);
        check("t6_err_cnt_after", 32'(blk_err_cnt), 32'd2);
        check("status_queue_empty", 32'(stat_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
